beep_sequencer: RTL and testbench
=================================

# beep_sequencer

Generates timed audible/visible beep patterns on the washer's beeper output from single-cycle event requests. It replaces the pass-through beeper path. Events come from the state controller, the run controller or the synchronized buttons (finish, error, key acknowledge), and the block turns them into N beeps of fixed on/off length. It runs in the divided `cp` clock domain, downstream of the input synchronizers and beside the View block.

## Interface
Parameters:
- `TICK_DIV`, default 25000: `clk` cycles per beep tick; must be ≥ 2.
- `ON_TICKS`, default 4: ticks the beeper is high per beep; must be ≥ 1.
- `OFF_TICKS`, default 4: ticks low between consecutive beeps; must be ≥ 1.

Ports:
- `clk` in 1: system clock. One clock only; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 1: start request, a one-cycle pulse.
- `count` in 3: number of beeps, 0..7. Sampled only in the cycle `req` is accepted.
- `cancel` in 1: abort the pattern in progress. Level-sampled each cycle.
- `beep` out 1: beeper/LED drive, registered.
- `busy` out 1: a pattern is in progress, registered.
- `done` out 1: one-cycle pulse when a pattern completes or is cancelled.

## Operation
- Reset values (async, while `rst_n`=0): `beep`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- State machine states: IDLE, ON, OFF.
- IDLE:
  - `req`=1, `cancel`=0, `count`≥1: latch `count` into the remaining counter, clear the prescaler and tick counter, go to ON.
  - `req`=1, `count`=0: stay IDLE and pulse `done` next cycle; no beep.
  - `req`=1 together with `cancel`=1: the request is dropped, with no `done`.
- ON (`beep`=1):
  - After ON_TICKS ticks, decrement remaining.
  - If remaining becomes 0: go to IDLE and pulse `done`. There is no trailing OFF phase.
  - Otherwise go to OFF.
- OFF (`beep`=0): after OFF_TICKS ticks, go to ON.
- Tick: the prescaler counts 0..TICK_DIV-1 and restarts at 0 on each state entry. Each state therefore lasts exactly ticks×TICK_DIV cycles.
- `req` while `busy`=1: ignored. The pattern is not restarted and the request is not queued.
- `cancel` while `busy`=1: next cycle `beep`=0, `busy`=0, state IDLE, and `done` pulses once.
- `cancel` in IDLE with no `req`: no effect.
- `count` is ignored outside the accept cycle. Changing it mid-pattern has no effect.
- Counter widths:
  - Prescaler: $clog2(TICK_DIV).
  - Tick counter: $clog2(max(ON_TICKS,OFF_TICKS)+1).
  - Remaining counter: 3 bits.
  - No wrap-around is reachable.

## Timing
- Latency: `req` accepted in cycle t gives `beep`=1 and `busy`=1 in cycle t+1.
- Each ON phase holds `beep`=1 for ON_TICKS×TICK_DIV cycles. Each OFF phase holds `beep`=0 for OFF_TICKS×TICK_DIV cycles.
- Total pattern for N≥1 beeps, from first `beep`=1 to the cycle `busy` falls: N·ON_TICKS·TICK_DIV + (N−1)·OFF_TICKS·TICK_DIV cycles.
- Completion:
  - `done` is asserted in the same cycle `busy` and `beep` fall to 0.
  - It lasts exactly one cycle.
  - A new `req` in that cycle is accepted, because the block is already IDLE.
- Cancel: `cancel` in cycle t gives `beep`=0, `busy`=0 and `done`=1 in cycle t+1.
- Reset mid-pattern: outputs clear immediately and asynchronously. There is no `done` pulse. After release the block is IDLE.

## Structure
- Shared package `washer_pkg`: the state encoding typedef (IDLE/ON/OFF, 2 bits) and the beep-count width constant (3). Default tick constants also go here so that View and the controllers agree on timing.
- One sub-module, `tick_gen`: prescaler with `clear` input and one-cycle `tick` output.
- The FSM, tick counter and remaining counter live in `beep_sequencer`.

## Test plan
All scenarios use TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1, so an ON phase is 8 cycles and an OFF phase is 4 cycles.
1. `req` with `count`=3 at cycle 0 → beep high for cycles 1–8, 13–20 and 25–32. `busy` is high for cycles 1–32. `done`=1 at cycle 33 only.
2. `req` with `count`=0 → `done` pulse at cycle 1. `beep` and `busy` stay 0.
3. `count`=2 pattern running, `req` with `count`=7 at cycle 5 → ignored. The pattern ends after 2 beeps with `done` at cycle 21.
4. `count`=5 pattern, `cancel` at cycle 10 → cycle 11 shows `beep`=0, `busy`=0 and `done`=1. A fresh `req` at cycle 12 produces `beep`=1 at cycle 13.
5. `req` and `cancel` together in IDLE → no beep, no busy, no done.
6. `rst_n` asserted at cycle 6 of a `count`=4 pattern → `beep` and `busy` drop asynchronously with no `done`. After release, `req` with `count`=1 produces exactly 8 beep cycles.

Source files
------------

// File: rtl/washer_pkg.sv
// Shared washer definitions.
// Holds the FSM state encoding used by the beep sequencer, the beep-count
// width and the default tick timing shared by View and the controllers.
// No ports: package only.
package washer_pkg;

    // Width of the beep-count request field (0..7 beeps).
    localparam int BEEP_CNT_W = 3;

    // Default beep timing: cp clock cycles per tick and ticks per phase.
    localparam int DEF_TICK_DIV  = 25000;
    localparam int DEF_ON_TICKS  = 4;
    localparam int DEF_OFF_TICKS = 4;

    // Sequencer state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ON   = 2'd1;
    localparam state_t ST_OFF  = 2'd2;

endpackage

// File: rtl/beep_sequencer_tick_gen.sv
// tick_gen: beep-tick prescaler.
// Counts 0..TICK_DIV-1 and flags the last count as a one-cycle tick.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   clear - restart the prescaler at 0 on the next cycle
//   tick  - high for one cycle every TICK_DIV cycles since the last clear
module tick_gen #(
    parameter int TICK_DIV = 25000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (clear || (pre == LAST)) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Decoded straight from the register so that the sequencer may use it to
    // form clear without creating a combinational loop.
    assign tick = (pre == LAST);

endmodule

// File: rtl/beep_sequencer.sv
// beep_sequencer: turns a single-cycle beep request into N timed beeps.
// Each beep is ON_TICKS ticks high, separated by OFF_TICKS ticks low, with
// no trailing low phase after the last beep.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   req    - one-cycle start request (ignored while busy)
//   count  - number of beeps, sampled only when req is accepted
//   cancel - abort the pattern in progress (level)
//   beep   - beeper / LED drive, registered
//   busy   - pattern in progress, registered
//   done   - one-cycle pulse when a pattern completes or is cancelled
module beep_sequencer
    import washer_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [BEEP_CNT_W-1:0] count,
    input  logic                  cancel,
    output logic                  beep,
    output logic                  busy,
    output logic                  done
);

    localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);

    state_t                state;
    logic [TW-1:0]         tick_cnt;
    logic [BEEP_CNT_W-1:0] remaining;
    logic                  tick;
    logic                  clear;
    logic                  phase_end;

    // Last tick of the current ON or OFF phase.
    always_comb begin
        phase_end = 1'b0;
        if (tick) begin
            if (state == ST_ON) begin
                phase_end = (tick_cnt == ON_LAST);
            end else if (state == ST_OFF) begin
                phase_end = (tick_cnt == OFF_LAST);
            end
        end
    end

    // Holding the prescaler clear in IDLE covers the accept cycle; clearing on
    // phase_end and cancel makes every state entry start from prescaler 0.
    assign clear = (state == ST_IDLE) || phase_end || cancel;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            remaining <= '0;
            beep      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A request coinciding with cancel is dropped silently.
                    if (req && !cancel) begin
                        if (count != '0) begin
                            state     <= ST_ON;
                            remaining <= count;
                            tick_cnt  <= '0;
                            beep      <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                ST_ON, ST_OFF: begin
                    if (cancel) begin
                        state     <= ST_IDLE;
                        tick_cnt  <= '0;
                        remaining <= '0;
                        beep      <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (tick) begin
                        if (!phase_end) begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end else begin
                            tick_cnt <= '0;
                            if (state == ST_ON) begin
                                remaining <= remaining - BEEP_CNT_W'(1);
                                beep      <= 1'b0;
                                if (remaining == BEEP_CNT_W'(1)) begin
                                    state <= ST_IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    state <= ST_OFF;
                                end
                            end else begin
                                state <= ST_ON;
                                beep  <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    // Unused encoding: fall back to a quiet IDLE.
                    state     <= ST_IDLE;
                    tick_cnt  <= '0;
                    remaining <= '0;
                    beep      <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beep_sequencer.sv
// Testbench for beep_sequencer (TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1).
// Stimulus feeds a pattern-level reference model that pushes one expected
// completion record per transaction; a monitor accumulates the observed
// beep/busy activity and checks it against the record on each done pulse.
module tb_beep_sequencer;

    localparam int TD     = 4;
    localparam int ONT    = 2;
    localparam int OFFT   = 1;
    localparam int ON_LEN  = ONT * TD;
    localparam int OFF_LEN = OFFT * TD;
    localparam int PERIOD  = ON_LEN + OFF_LEN;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [2:0] cnt;
    logic       cancel;
    logic       beep;
    logic       busy;
    logic       done;

    beep_sequencer #(
        .TICK_DIV (TD),
        .ON_TICKS (ONT),
        .OFF_TICKS(OFFT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .count (cnt),
        .cancel(cancel),
        .beep  (beep),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        int first_beep;
        int done_cyc;
        int beeps;
        int edges;
        int busy_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   cur_s  = 0;
    int   pend   = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp_v);
        end
    endtask

    // Reference model: a pattern started at cycle s with N beeps is busy for
    // cycles s..s+N*ON_LEN+(N-1)*OFF_LEN-1 and beeps where (c-s) mod PERIOD < ON_LEN.
    task automatic model(input int t, input bit r, input logic [2:0] c, input bit k);
        exp_t e;
        int   n;
        int   nb;
        bit   busy_now;
        busy_now = (t >= cur_s) && (t <= pend);
        if (!busy_now) begin
            if (r && !k) begin
                if (c == 3'd0) begin
                    e = '{-1, t + 1, 0, 0, 0};
                    sb.push_back(e);
                end else begin
                    n     = int'(c);
                    cur_s = t + 1;
                    pend  = cur_s + n * ON_LEN + (n - 1) * OFF_LEN - 1;
                    e     = '{cur_s, pend + 1, n * ON_LEN, n, pend + 1 - cur_s};
                    sb.push_back(e);
                end
            end
        end else if (k) begin
            e  = sb.pop_back();
            nb = 0;
            for (int cc = cur_s; cc <= t; cc++) begin
                if (((cc - cur_s) % PERIOD) < ON_LEN) nb++;
            end
            e.done_cyc = t + 1;
            e.beeps    = nb;
            e.edges    = (t - cur_s) / PERIOD + 1;
            e.busy_cyc = t + 1 - cur_s;
            sb.push_back(e);
            pend = t;
        end
    endtask

    task automatic drive(input bit r, input logic [2:0] c, input bit k);
        @(negedge clk);
        req    = r;
        cnt    = c;
        cancel = k;
        model(cyc, r, c, k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'($urandom_range(0, 7)), 1'b0);
    endtask

    task automatic drain();
        while (cyc <= pend + 2) drive(1'b0, 3'($urandom_range(0, 7)), 1'b0);
        idle(2);
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge.
    task automatic do_reset();
        @(negedge clk);
        req    = 1'b0;
        cancel = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_beep", int'(beep), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        sb.delete();
        pend = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: accumulate activity between done pulses and compare on done.
    initial begin : monitor
        int   mfirst;
        int   mbeeps;
        int   medges;
        int   mbusy;
        bit   mprev;
        exp_t e;
        mfirst = -1; mbeeps = 0; medges = 0; mbusy = 0; mprev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mfirst = -1; mbeeps = 0; medges = 0; mbusy = 0; mprev = 1'b0;
            end else begin
                if (beep === 1'b1) begin
                    if (mfirst < 0) mfirst = cyc;
                    mbeeps++;
                    if (!mprev) medges++;
                end
                mprev = (beep === 1'b1);
                if (busy === 1'b1) mbusy++;
                if (done === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done at cycle %0d: actual=1 expected=0", cyc);
                    end else begin
                        e = sb.pop_front();
                        check("done_cycle", cyc, e.done_cyc);
                        check("first_beep_cycle", mfirst, e.first_beep);
                        check("beep_cycles", mbeeps, e.beeps);
                        check("beep_count", medges, e.edges);
                        check("busy_cycles", mbusy, e.busy_cyc);
                        check("beep_at_done", int'(beep), 0);
                        check("busy_at_done", int'(busy), 0);
                    end
                    mfirst = -1; mbeeps = 0; medges = 0; mbusy = 0; mprev = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit         r;
        bit         k;
        logic [2:0] c;

        rst_n  = 1'b0;
        req    = 1'b0;
        cnt    = 3'd0;
        cancel = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_beep", int'(beep), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst_n = 1'b1;
        idle(2);

        // 1: three beeps
        drive(1'b1, 3'd3, 1'b0);
        drain();

        // 2: zero beeps, done only
        drive(1'b1, 3'd0, 1'b0);
        drain();

        // 3: request while busy is ignored
        drive(1'b1, 3'd2, 1'b0);
        idle(4);
        drive(1'b1, 3'd7, 1'b0);
        drain();

        // 4: cancel mid-pattern, then immediate fresh request
        drive(1'b1, 3'd5, 1'b0);
        idle(9);
        drive(1'b0, 3'd0, 1'b1);
        idle(1);
        drive(1'b1, 3'd1, 1'b0);
        drain();

        // 5: req together with cancel in IDLE is dropped
        drive(1'b1, 3'd3, 1'b1);
        drive(1'b0, 3'd0, 1'b0);
        check("req_cancel_beep", int'(beep), 0);
        check("req_cancel_busy", int'(busy), 0);
        check("req_cancel_done", int'(done), 0);
        drain();

        // 6: reset mid-pattern, then a single beep
        drive(1'b1, 3'd4, 1'b0);
        idle(5);
        do_reset();
        drive(1'b1, 3'd1, 1'b0);
        drain();

        // new request in the same cycle as done
        drive(1'b1, 3'd1, 1'b0);
        while (cyc <= pend) drive(1'b0, 3'd0, 1'b0);
        drive(1'b1, 3'd2, 1'b0);
        drain();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 19) == 0);
            k = ($urandom_range(0, 149) == 0);
            c = 3'($urandom_range(0, 7));
            if (i == 1500) do_reset();
            else drive(r, c, k);
        end
        drive(1'b0, 3'd0, 1'b0);
        drain();

        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
